// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage F/D/E/M/W pipeline.
//
// Produces the PC and pipeline-register load enables, F/D and D/E flushes,
// and PC redirect selection from bus-busy status, load-use detection and
// execute-stage redirects. A small FSM (Idle/Drain/Load) holds a redirect
// target while an instruction fetch is still outstanding and drops the
// wrong-path response when it completes.
//
// Build option: define PIPE_CTRL_PERF_EN to implement the 64-bit performance
// counters; otherwise perf_*_o are tied to zero and no counter flops exist.
//
// Ports:
//   clk_i, reset_i               clock, synchronous active-high reset
//   i_busy_i, d_busy_i           instruction / data bus access outstanding
//   d_ra{1,2}_i, d_ra{1,2}_en_i  decode-stage source registers and read flags
//   e_valid_i, e_wa_i, e_regwen_i, e_is_load_i   execute-stage writeback info
//   e_redirect_i, e_target_i     execute-stage redirect and its target
//   en_{pc,fd,de,em,mw}_o        register load enables
//   flush_fd_o, flush_de_o       load a bubble into F/D, D/E
//   pc_sel_o, pc_target_o        PC redirect select and target
//   f_drop_o                     discard the fetch response completing now
//   perf_{stall,flush,lduse}_o   performance counters
module pipe_hazard_ctrl #(
  parameter int unsigned PC_W = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            i_busy_i,
  input  logic            d_busy_i,
  input  logic [4:0]      d_ra1_i,
  input  logic [4:0]      d_ra2_i,
  input  logic            d_ra1_en_i,
  input  logic            d_ra2_en_i,
  input  logic            e_valid_i,
  input  logic [4:0]      e_wa_i,
  input  logic            e_regwen_i,
  input  logic            e_is_load_i,
  input  logic            e_redirect_i,
  input  logic [PC_W-1:0] e_target_i,
  output logic            en_pc_o,
  output logic            en_fd_o,
  output logic            en_de_o,
  output logic            en_em_o,
  output logic            en_mw_o,
  output logic            flush_fd_o,
  output logic            flush_de_o,
  output logic            pc_sel_o,
  output logic [PC_W-1:0] pc_target_o,
  output logic            f_drop_o,
  output logic [63:0]     perf_stall_o,
  output logic [63:0]     perf_flush_o,
  output logic [63:0]     perf_lduse_o
);

  typedef enum logic [1:0] {StIdle, StDrain, StLoad} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            lu, rd;

  assign lu = e_valid_i & e_is_load_i & e_regwen_i & (e_wa_i != 5'd0) &
              ((d_ra1_en_i & (d_ra1_i == e_wa_i)) | (d_ra2_en_i & (d_ra2_i == e_wa_i)));
  assign rd = e_valid_i & e_redirect_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      StIdle: begin
        // A redirect with a fetch in flight must wait for that response.
        if (!d_busy_i && rd && i_busy_i) begin
          state_d = StDrain;
          tgt_d   = e_target_i;
        end
      end
      StDrain: begin
        if (!i_busy_i) state_d = d_busy_i ? StLoad : StIdle;
      end
      StLoad: begin
        if (!d_busy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    en_pc_o     = 1'b1;
    en_fd_o     = 1'b1;
    en_de_o     = 1'b1;
    en_em_o     = 1'b1;
    en_mw_o     = 1'b1;
    flush_fd_o  = 1'b0;
    flush_de_o  = 1'b0;
    pc_sel_o    = 1'b0;
    pc_target_o = e_target_i;
    f_drop_o    = 1'b0;
    if (reset_i) begin
      en_pc_o    = 1'b0;
      flush_fd_o = 1'b1;
      flush_de_o = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_busy_i) begin
            // Freeze everything; a pending redirect is re-evaluated later.
            en_pc_o = 1'b0;
            en_fd_o = 1'b0;
            en_de_o = 1'b0;
            en_em_o = 1'b0;
            en_mw_o = 1'b0;
          end else if (rd) begin
            flush_fd_o = 1'b1;
            flush_de_o = 1'b1;
            en_pc_o    = !i_busy_i;
            pc_sel_o   = !i_busy_i;
          end else if (lu) begin
            en_pc_o    = 1'b0;
            en_fd_o    = 1'b0;
            flush_de_o = 1'b1;
          end else if (i_busy_i) begin
            en_pc_o    = 1'b0;
            flush_fd_o = 1'b1;
          end
        end
        StDrain: begin
          pc_target_o = tgt_q;
          flush_fd_o  = 1'b1;
          en_de_o     = !d_busy_i;
          en_em_o     = !d_busy_i;
          en_mw_o     = !d_busy_i;
          if (i_busy_i) begin
            en_pc_o = 1'b0;
          end else begin
            // The response arriving now is wrong-path.
            f_drop_o = 1'b1;
            en_pc_o  = !d_busy_i;
            pc_sel_o = !d_busy_i;
          end
        end
        StLoad: begin
          pc_target_o = tgt_q;
          pc_sel_o    = 1'b1;
          flush_fd_o  = 1'b1;
          en_pc_o     = !d_busy_i;
          en_de_o     = !d_busy_i;
          en_em_o     = !d_busy_i;
          en_mw_o     = !d_busy_i;
        end
        default: en_pc_o = 1'b0;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] perf_stall_q, perf_flush_q, perf_lduse_q;
  logic        flush_evt, lduse_evt;

  assign flush_evt = !reset_i && (state_q == StIdle) && rd && !d_busy_i;
  assign lduse_evt = !reset_i && (state_q == StIdle) && !rd && lu && !d_busy_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_lduse_q <= '0;
    end else begin
      if (!en_pc_o) perf_stall_q <= perf_stall_q + 64'd1;
      if (flush_evt) perf_flush_q <= perf_flush_q + 64'd1;
      if (lduse_evt) perf_lduse_q <= perf_lduse_q + 64'd1;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
  assign perf_lduse_o = perf_lduse_q;
`else
  assign perf_stall_o = '0;
  assign perf_flush_o = '0;
  assign perf_lduse_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the stimulus process drives one
// directed vector per cycle and queues its hand-computed expectation; the
// monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_busy, d_busy;
  logic [4:0]  d_ra1, d_ra2, e_wa;
  logic        d_ra1_en, d_ra2_en, e_valid, e_regwen, e_is_load, e_redirect;
  logic [63:0] e_target;
  logic        en_pc, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, pc_sel, f_drop;
  logic [63:0] pc_target, perf_stall, perf_flush, perf_lduse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.PC_W(64)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .i_busy_i     (i_busy),
    .d_busy_i     (d_busy),
    .d_ra1_i      (d_ra1),
    .d_ra2_i      (d_ra2),
    .d_ra1_en_i   (d_ra1_en),
    .d_ra2_en_i   (d_ra2_en),
    .e_valid_i    (e_valid),
    .e_wa_i       (e_wa),
    .e_regwen_i   (e_regwen),
    .e_is_load_i  (e_is_load),
    .e_redirect_i (e_redirect),
    .e_target_i   (e_target),
    .en_pc_o      (en_pc),
    .en_fd_o      (en_fd),
    .en_de_o      (en_de),
    .en_em_o      (en_em),
    .en_mw_o      (en_mw),
    .flush_fd_o   (flush_fd),
    .flush_de_o   (flush_de),
    .pc_sel_o     (pc_sel),
    .pc_target_o  (pc_target),
    .f_drop_o     (f_drop),
    .perf_stall_o (perf_stall),
    .perf_flush_o (perf_flush),
    .perf_lduse_o (perf_lduse)
  );

  // en bit order {pc,fd,de,em,mw}; fl bit order {fd,de}; masks select checked bits.
  typedef struct {
    string       name;
    logic [4:0]  en;
    logic [4:0]  en_m;
    logic [1:0]  fl;
    logic [1:0]  fl_m;
    logic        chk_sel;
    logic        sel;
    logic        drop;
    logic        chk_tgt;
    logic [63:0] tgt;
    logic        chk_perf;
    logic [63:0] p_stall;
    logic [63:0] p_flush;
    logic [63:0] p_lduse;
  } exp_t;

  exp_t sb[$];

  function automatic logic [63:0] pv(input logic [63:0] v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return (v & 64'd0);
`endif
  endfunction

  function automatic exp_t mk(input string n, input logic [4:0] en, input logic [4:0] en_m,
                              input logic [1:0] fl, input logic [1:0] fl_m,
                              input logic [1:0] sel, input logic drop);
    exp_t e;
    e.name = n; e.en = en; e.en_m = en_m; e.fl = fl; e.fl_m = fl_m;
    e.chk_sel = sel[1]; e.sel = sel[0]; e.drop = drop;
    e.chk_tgt = 1'b0; e.tgt = '0;
    e.chk_perf = 1'b0; e.p_stall = '0; e.p_flush = '0; e.p_lduse = '0;
    return e;
  endfunction

  function automatic exp_t with_tgt(input exp_t e, input logic [63:0] t);
    exp_t r = e;
    r.chk_tgt = 1'b1; r.tgt = t;
    return r;
  endfunction

  function automatic exp_t with_perf(input exp_t e, input logic [63:0] s, input logic [63:0] f,
                                     input logic [63:0] l);
    exp_t r = e;
    r.chk_perf = 1'b1; r.p_stall = pv(s); r.p_flush = pv(f); r.p_lduse = pv(l);
    return r;
  endfunction

  task automatic chk(input string n, input string f, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s: got %0h want %0h", n, f, act, exp);
    end
  endtask

  // Monitor: outputs are combinational and presented every cycle.
  exp_t me;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk(me.name, "en", 64'({en_pc, en_fd, en_de, en_em, en_mw} & me.en_m),
          64'(me.en & me.en_m));
      chk(me.name, "flush", 64'({flush_fd, flush_de} & me.fl_m), 64'(me.fl & me.fl_m));
      chk(me.name, "f_drop", 64'(f_drop), 64'(me.drop));
      if (me.chk_sel) chk(me.name, "pc_sel", 64'(pc_sel), 64'(me.sel));
      if (me.chk_tgt) chk(me.name, "pc_target", pc_target, me.tgt);
      if (me.chk_perf) begin
        chk(me.name, "perf_stall", perf_stall, me.p_stall);
        chk(me.name, "perf_flush", perf_flush, me.p_flush);
        chk(me.name, "perf_lduse", perf_lduse, me.p_lduse);
      end
    end
  end

  task automatic clr();
    reset = 1'b0; i_busy = 1'b0; d_busy = 1'b0;
    d_ra1 = '0; d_ra2 = '0; d_ra1_en = 1'b0; d_ra2_en = 1'b0;
    e_valid = 1'b0; e_wa = '0; e_regwen = 1'b0; e_is_load = 1'b0;
    e_redirect = 1'b0; e_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_load(input logic [4:0] wa);
    e_valid = 1'b1; e_is_load = 1'b1; e_regwen = 1'b1; e_wa = wa;
  endtask

  task automatic set_rd(input logic [63:0] t);
    e_valid = 1'b1; e_redirect = 1'b1; e_target = t;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    // Reset held for three checked cycles.
    tick(); reset = 1'b1;
    sb.push_back(mk("rst0", 5'b01111, 5'b11111, 2'b11, 2'b11, 2'b10, 1'b0));
    tick(); reset = 1'b1;
    sb.push_back(mk("rst1", 5'b01111, 5'b11111, 2'b11, 2'b11, 2'b10, 1'b0));
    tick(); reset = 1'b1;
    sb.push_back(with_perf(mk("rst2", 5'b01111, 5'b11111, 2'b11, 2'b11, 2'b10, 1'b0), 0, 0, 0));
    tick();
    sb.push_back(with_perf(mk("post_rst", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0),
                           0, 0, 0));
    // Load-use through rs2: one bubble.
    tick(); set_load(5'd5); d_ra2 = 5'd5; d_ra2_en = 1'b1;
    sb.push_back(with_perf(mk("lu_ra2", 5'b00111, 5'b11111, 2'b01, 2'b11, 2'b10, 1'b0),
                           0, 0, 0));
    tick();
    sb.push_back(with_perf(mk("lu_done", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0),
                           1, 0, 1));
    // x0 destination never stalls.
    tick(); set_load(5'd0); d_ra2 = 5'd0; d_ra2_en = 1'b1;
    sb.push_back(mk("lu_wa0", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0));
    // Redirect with no fetch pending.
    tick(); set_rd(64'h8000_0100);
    sb.push_back(with_tgt(mk("rd_now", 5'b10011, 5'b10011, 2'b11, 2'b11, 2'b11, 1'b0),
                          64'h8000_0100));
    tick();
    sb.push_back(with_perf(mk("rd_after", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0),
                           1, 1, 1));
    // Redirect with fetch pending, drained over three more busy cycles.
    tick(); set_rd(64'h8000_0200); i_busy = 1'b1;
    sb.push_back(mk("rd_busy", 5'b00011, 5'b10011, 2'b11, 2'b11, 2'b00, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick(); i_busy = 1'b1;
      sb.push_back(with_tgt(mk("drain", 5'b00000, 5'b10000, 2'b10, 2'b10, 2'b00, 1'b0),
                            64'h8000_0200));
    end
    tick();
    sb.push_back(with_perf(with_tgt(mk("drain_exit", 5'b10000, 5'b10000, 2'b10, 2'b10, 2'b11,
                                       1'b1), 64'h8000_0200), 5, 2, 1));
    tick();
    sb.push_back(mk("idle2", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0));
    // Drain exit collides with a 2-cycle data-bus access.
    tick(); set_rd(64'h8000_0300); i_busy = 1'b1;
    sb.push_back(mk("rd_busy2", 5'b00011, 5'b10011, 2'b11, 2'b11, 2'b00, 1'b0));
    tick(); i_busy = 1'b1;
    sb.push_back(mk("drain2", 5'b00000, 5'b10000, 2'b10, 2'b10, 2'b00, 1'b0));
    tick(); d_busy = 1'b1;
    sb.push_back(with_tgt(mk("exit_dbusy", 5'b00000, 5'b10111, 2'b10, 2'b10, 2'b00, 1'b1),
                          64'h8000_0300));
    tick(); d_busy = 1'b1;
    sb.push_back(with_tgt(mk("load_dbusy", 5'b00000, 5'b10000, 2'b10, 2'b10, 2'b11, 1'b0),
                          64'h8000_0300));
    tick();
    sb.push_back(with_tgt(mk("load_exit", 5'b10000, 5'b10000, 2'b10, 2'b10, 2'b11, 1'b0),
                          64'h8000_0300));
    tick();
    sb.push_back(with_perf(mk("idle3", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0),
                           9, 3, 1));
    // Redirect while the data bus is busy is deferred.
    tick(); set_rd(64'h8000_0400); d_busy = 1'b1;
    sb.push_back(mk("rd_dbusy", 5'b00000, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0));
    tick(); set_rd(64'h8000_0400); d_busy = 1'b1;
    sb.push_back(with_perf(mk("rd_dbusy2", 5'b00000, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0),
                           10, 3, 1));
    tick(); set_rd(64'h8000_0400);
    sb.push_back(with_perf(with_tgt(mk("rd_taken", 5'b10011, 5'b10011, 2'b11, 2'b11, 2'b11,
                                       1'b0), 64'h8000_0400), 11, 3, 1));
    tick();
    sb.push_back(with_perf(mk("idle4", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0),
                           11, 4, 1));
    // Reset in the middle of a drain: no drop, back to idle with e_target.
    tick(); set_rd(64'h8000_0500); i_busy = 1'b1;
    sb.push_back(mk("rd_busy3", 5'b00011, 5'b10011, 2'b11, 2'b11, 2'b00, 1'b0));
    tick(); reset = 1'b1; i_busy = 1'b1;
    sb.push_back(mk("rst_drain", 5'b01111, 5'b11111, 2'b11, 2'b11, 2'b10, 1'b0));
    tick(); e_target = 64'h1234;
    sb.push_back(with_perf(with_tgt(mk("post_rst2", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10,
                                       1'b0), 64'h1234), 0, 0, 0));
    // Load-use through rs1, then the same with the read flag off.
    tick(); set_load(5'd7); d_ra1 = 5'd7; d_ra1_en = 1'b1;
    sb.push_back(mk("lu_ra1", 5'b00111, 5'b11111, 2'b01, 2'b11, 2'b10, 1'b0));
    tick(); set_load(5'd7); d_ra1 = 5'd7;
    sb.push_back(mk("lu_ra1_off", 5'b11111, 5'b11111, 2'b00, 2'b11, 2'b10, 1'b0));
    // Plain fetch stall.
    tick(); i_busy = 1'b1;
    sb.push_back(mk("ibusy", 5'b01111, 5'b11111, 2'b10, 2'b11, 2'b10, 1'b0));
    tick();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
